// File: rtl/jtkiwi_arb_pkg.sv
// Shared types and constants for the jtkiwi graphics-ROM arbiter.
// Optional watchdog feature is enabled with the JTKIWI_ARB_WDOG_EN macro.
package jtkiwi_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Requester indices (also the encoding of the round-robin pointer)
  localparam logic OBJ = 1'b0;
  localparam logic SCR = 1'b1;

  // Default watchdog limit in cycles
  localparam logic [7:0] WDOG_MAX_DEF = 8'd255;

endpackage

// File: rtl/jtkiwi_arb_slot.sv
// One requester's cached ROM slot: remembers the last filled address and
// its data, and reports a hit combinationally against the live address.
module jtkiwi_arb_slot
  import jtkiwi_arb_pkg::*;
#(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic          cs_i,
  input  logic          inval_i,
  input  logic          wr_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  output logic          ok_o,
  output logic          miss_o,
  output logic [31:0]   data_o
);

  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;

  // Fill on write strobe; invalidate when a new grant for this side starts
  always_comb begin
    last_addr_d = last_addr_q;
    valid_d     = valid_q;
    data_d      = data_q;
    if (wr_i) begin
      last_addr_d = wr_addr_i;
      valid_d     = 1'b1;
      data_d      = wr_data_i;
    end else if (inval_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= 32'd0;
    end else begin
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign ok_o   = valid_q & cs_i & (addr_i == last_addr_q);
  assign miss_o = cs_i & ~ok_o;
  assign data_o = data_q;

endmodule

// File: rtl/jtkiwi_rom_arb.sv
// Round-robin arbiter sharing one SDRAM graphics-ROM port between the
// object and tile draw engines. Each side gets a one-entry cached slot;
// misses are serialised onto the downstream port.
// Handshake: a requester holds *_cs and *_addr stable until *_ok; the
// downstream port sees rom_cs held high with a stable rom_addr until
// rom_ok is accepted or the grant is aborted, then rom_cs drops for at
// least two cycles before the next grant.
// Optional feature: define JTKIWI_ARB_WDOG_EN to add a grant watchdog.
module jtkiwi_rom_arb
  import jtkiwi_arb_pkg::*;
#(
  parameter int         AW       = 18,
  parameter logic [7:0] WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] obj_addr,
  input  logic          obj_cs,
  output logic          obj_ok,
  output logic [31:0]   obj_data,
  input  logic [AW-1:0] scr_addr,
  input  logic          scr_cs,
  output logic          scr_ok,
  output logic [31:0]   scr_data,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [31:0]   rom_data,
  output logic          wdog_err
);

  arb_state_e    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          win_q, win_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          rom_cs_q, rom_cs_d;
  logic          obj_miss, scr_miss;
  logic          fill, inval;
  logic          win_cs, abort_req;
  logic [AW-1:0] win_addr;
  logic          wdog_hit, wdog_trip;

  jtkiwi_arb_slot #(.AW(AW)) u_obj (
    .clk(clk), .rst(rst), .addr_i(obj_addr), .cs_i(obj_cs),
    .inval_i(inval & (win_d == OBJ)), .wr_i(fill & (win_q == OBJ)),
    .wr_addr_i(rom_addr_q), .wr_data_i(rom_data),
    .ok_o(obj_ok), .miss_o(obj_miss), .data_o(obj_data)
  );

  jtkiwi_arb_slot #(.AW(AW)) u_scr (
    .clk(clk), .rst(rst), .addr_i(scr_addr), .cs_i(scr_cs),
    .inval_i(inval & (win_d == SCR)), .wr_i(fill & (win_q == SCR)),
    .wr_addr_i(rom_addr_q), .wr_data_i(rom_data),
    .ok_o(scr_ok), .miss_o(scr_miss), .data_o(scr_data)
  );

  // The winner abandons its grant by dropping cs or moving its address
  assign win_cs    = (win_q == SCR) ? scr_cs : obj_cs;
  assign win_addr  = (win_q == SCR) ? scr_addr : obj_addr;
  assign abort_req = ~win_cs | (win_addr != rom_addr_q);

  // Next-state, grant selection and downstream request control
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    fill       = 1'b0;
    inval      = 1'b0;
    wdog_trip  = 1'b0;
    case (state_q)
      IDLE: begin
        if (obj_miss | scr_miss) begin
          win_d      = (obj_miss & scr_miss) ? ptr_q : (scr_miss ? SCR : OBJ);
          rom_addr_d = (win_d == SCR) ? scr_addr : obj_addr;
          rom_cs_d   = 1'b1;
          inval      = 1'b1;
          state_d    = WAIT1;
        end
      end
      WAIT1: begin
        // rom_ok here still belongs to the previous address
        rom_cs_d = ~abort_req;
        state_d  = abort_req ? DONE : WAIT;
      end
      WAIT: begin
        if (abort_req) begin
          rom_cs_d = 1'b0;
          state_d  = DONE;
        end else if (rom_ok) begin
          fill     = 1'b1;
          rom_cs_d = 1'b0;
          ptr_d    = ~ptr_q;
          state_d  = DONE;
        end else if (wdog_hit) begin
          wdog_trip = 1'b1;
          rom_cs_d  = 1'b0;
          ptr_d     = ~ptr_q;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, pointer and downstream registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= OBJ;
      win_q      <= OBJ;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;

`ifdef JTKIWI_ARB_WDOG_EN
  logic [7:0] wdog_cnt_q, wdog_cnt_d;
  logic       wdog_err_q, wdog_err_d;

  // Count cycles spent in a grant; zero whenever no grant is open
  always_comb begin
    wdog_cnt_d = 8'd0;
    if (state_q == WAIT1 || state_q == WAIT) begin
      wdog_cnt_d = (wdog_cnt_q == 8'hFF) ? wdog_cnt_q : wdog_cnt_q + 8'd1;
    end
    wdog_err_d = wdog_err_q | wdog_trip;
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= 8'd0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_hit = (wdog_cnt_q >= WDOG_MAX);
  assign wdog_err = wdog_err_q;
`else
  logic wdog_unused;
  assign wdog_unused = ^{WDOG_MAX, wdog_trip};
  assign wdog_hit    = 1'b0;
  assign wdog_err    = 1'b0;
`endif

endmodule
